// File: rtl/bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_sequencer
// Purpose  : Owns the shared 19-bit system bus together with the 6502 clock
//            and reset. After reset the SPI boot loader owns the bus. The bus
//            is then handed to the CPU, which runs its reset sequence. After
//            that the bus is lent to a secondary DMA requester by stopping the
//            CPU on a bus-cycle boundary. Every change of bus owner passes
//            through TURNAROUND idle cycles in which no master drives the bus.
//
// Ports    : clock_i           system clock (8 MHz)
//            reset_n_i         asynchronous active-low reset
//            boot_done_i       boot loader finished and released the bus
//            cpu_cycle_end_i   one-cycle pulse at the end of each 6502 cycle
//            dma_req_i         level request from the DMA master
//            boot_grant_o      boot loader may drive the bus
//            dma_grant_o       DMA master may drive the bus
//            cpu_bus_disable_o HIGH = 6502 address/data/rw drivers disabled
//            clock_stop_o      LOW  = 6502 clock stopped
//            cpu_reset_n_o     6502 reset, active low
//            dma_timeout_o     one-cycle pulse when the watchdog revokes a grant
//
// Options  : DMA_WATCHDOG_EN  when defined, a DMA grant is revoked after
//                             DMA_MAX_HOLD cycles and the request is masked
//                             until it has been seen low. When undefined,
//                             dma_timeout_o is tied low.
//
// Revision : 1.0  initial release
// ============================================================================
module bus_sequencer #(
  parameter int TURNAROUND       = 2,
  parameter int CPU_RESET_CYCLES = 16,
  parameter int DMA_MAX_HOLD     = 1024
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic boot_done_i,
  input  logic cpu_cycle_end_i,
  input  logic dma_req_i,
  output logic boot_grant_o,
  output logic dma_grant_o,
  output logic cpu_bus_disable_o,
  output logic clock_stop_o,
  output logic cpu_reset_n_o,
  output logic dma_timeout_o
);

  // One shared counter; it is sized for the largest cycle count it may hold.
  localparam int MAX_AB    = (TURNAROUND > CPU_RESET_CYCLES) ? TURNAROUND : CPU_RESET_CYCLES;
  localparam int MAX_PARAM = (MAX_AB > DMA_MAX_HOLD) ? MAX_AB : DMA_MAX_HOLD;
  localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'((CPU_RESET_CYCLES > 0) ? CPU_RESET_CYCLES - 1 : 0);
`ifdef DMA_WATCHDOG_EN
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((DMA_MAX_HOLD > 0) ? DMA_MAX_HOLD - 1 : 0);
`endif

  typedef enum logic [2:0] {
    S_BOOT        = 3'd0,
    S_HANDOVER    = 3'd1,
    S_CPU_RESET   = 3'd2,
    S_CPU_RUN     = 3'd3,
    S_DMA_STOP    = 3'd4,
    S_DMA_TURN    = 3'd5,
    S_DMA         = 3'd6,
    S_DMA_RELEASE = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boot_grant_q, boot_grant_d;
  logic             dma_grant_q, dma_grant_d;
  logic             bus_dis_q, bus_dis_d;
  logic             clk_run_q, clk_run_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  // Set once the CPU has completed a bus cycle since it last got the bus
  // back; a new DMA request is only accepted while this is set.
  logic             seen_q, seen_d;
  logic             w_req_eff;

`ifdef DMA_WATCHDOG_EN
  logic             mask_q, mask_d;
  logic             timeout_q, timeout_d;

  // After a watchdog revoke the request stays masked until it is seen low.
  assign w_req_eff = dma_req_i & ~mask_q;
`else
  assign w_req_eff = dma_req_i;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    boot_grant_d = boot_grant_q;
    dma_grant_d  = dma_grant_q;
    bus_dis_d    = bus_dis_q;
    clk_run_d    = clk_run_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    seen_d       = seen_q;
`ifdef DMA_WATCHDOG_EN
    timeout_d    = 1'b0;
    mask_d       = dma_req_i ? mask_q : 1'b0;
`endif

    case (state_q)
      S_BOOT: begin
        if (boot_done_i) begin
          boot_grant_d = 1'b0;
          if (TURNAROUND == 0) begin
            bus_dis_d = 1'b0;
            clk_run_d = 1'b1;
            state_d   = S_CPU_RESET;
          end else begin
            state_d   = S_HANDOVER;
          end
        end
      end

      S_HANDOVER: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == TURN_LAST) begin
          bus_dis_d = 1'b0;
          clk_run_d = 1'b1;
          state_d   = S_CPU_RESET;
        end
      end

      S_CPU_RESET: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == RESET_LAST) begin
          cpu_rst_n_d = 1'b1;
          seen_d      = 1'b1;
          state_d     = S_CPU_RUN;
        end
      end

      S_CPU_RUN: begin
        // Eligibility uses the registered flag, so the cycle end must have
        // happened in an earlier cycle than the request is acted on.
        if (cpu_cycle_end_i) begin
          seen_d = 1'b1;
        end
        if (w_req_eff && seen_q) begin
          state_d = S_DMA_STOP;
        end
      end

      S_DMA_STOP: begin
        // A request withdrawn before the cycle boundary wins over a
        // coincident cycle end: the CPU simply keeps running.
        if (!w_req_eff) begin
          state_d = S_CPU_RUN;
        end else if (cpu_cycle_end_i) begin
          clk_run_d = 1'b0;
          bus_dis_d = 1'b1;
          if (TURNAROUND == 0) begin
            dma_grant_d = 1'b1;
            state_d     = S_DMA;
          end else begin
            state_d     = S_DMA_TURN;
          end
        end
      end

      S_DMA_TURN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == TURN_LAST) begin
          dma_grant_d = 1'b1;
          state_d     = S_DMA;
        end
      end

      S_DMA: begin
        if (!dma_req_i) begin
          dma_grant_d = 1'b0;
          if (TURNAROUND == 0) begin
            bus_dis_d = 1'b0;
            clk_run_d = 1'b1;
            seen_d    = 1'b0;
            state_d   = S_CPU_RUN;
          end else begin
            state_d   = S_DMA_RELEASE;
          end
        end
`ifdef DMA_WATCHDOG_EN
        else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == HOLD_LAST) begin
            dma_grant_d = 1'b0;
            timeout_d   = 1'b1;
            mask_d      = 1'b1;
            if (TURNAROUND == 0) begin
              bus_dis_d = 1'b0;
              clk_run_d = 1'b1;
              seen_d    = 1'b0;
              state_d   = S_CPU_RUN;
            end else begin
              state_d   = S_DMA_RELEASE;
            end
          end
        end
`endif
      end

      S_DMA_RELEASE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == TURN_LAST) begin
          bus_dis_d = 1'b0;
          clk_run_d = 1'b1;
          seen_d    = 1'b0;
          state_d   = S_CPU_RUN;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    // Every state entry starts its count from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_BOOT;
      cnt_q        <= '0;
      boot_grant_q <= 1'b1;
      dma_grant_q  <= 1'b0;
      bus_dis_q    <= 1'b1;
      clk_run_q    <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      boot_grant_q <= boot_grant_d;
      dma_grant_q  <= dma_grant_d;
      bus_dis_q    <= bus_dis_d;
      clk_run_q    <= clk_run_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      seen_q       <= seen_d;
    end
  end

`ifdef DMA_WATCHDOG_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mask_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end

  assign dma_timeout_o = timeout_q;
`else
  assign dma_timeout_o = 1'b0;
`endif

  assign boot_grant_o      = boot_grant_q;
  assign dma_grant_o       = dma_grant_q;
  assign cpu_bus_disable_o = bus_dis_q;
  assign clock_stop_o      = clk_run_q;
  assign cpu_reset_n_o     = cpu_rst_n_q;

endmodule
`default_nettype wire
